// File: rtl/alu_pkg.sv
// Shared ALU definitions: word width, flag bit positions and the packed
// flag record used by the ALU, the result buffer and the display stage.
package alu_pkg;

    localparam int ALU_W  = 32;

    localparam int FLG_C  = 0;
    localparam int FLG_Z  = 1;
    localparam int FLG_V  = 2;
    localparam int FLG_OP = 3;

    // Bit order matches FLG_* so the struct can be used as a plain 4-bit vector.
    typedef struct packed {
        logic op;
        logic v;
        logic z;
        logic c;
    } alu_flags_t;

    function automatic alu_flags_t make_flags(input logic c, input logic z,
                                              input logic v, input logic op);
        logic [3:0] f;
        f         = '0;
        f[FLG_C]  = c;
        f[FLG_Z]  = z;
        f[FLG_V]  = v;
        f[FLG_OP] = op;
        return alu_flags_t'(f);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that can seed the counter
// with the current cycle's increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             load_one,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over increment; the clear value is this cycle's contribution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= {{(CNT_W-1){1'b0}}, load_one};
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Result buffer behind the add/sub ALU: a small FIFO of result words with
// their flags, a valid/ready output, and bring-up statistics.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_sub_add,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             ovf_sticky,
    output logic             zero_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic   push;
    logic   pop;
    logic   zero_mis;
    entry_t in_entry;

    // Handshake status comes from count only, so there is no in->out path.
    assign in_ready  = (count != CNT_FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign zero_mis  = in_zero != (in_result == '0);

    assign in_entry.result = in_result;
    assign in_entry.flags  = make_flags(in_carry, in_zero, in_overflow, in_sub_add);

    assign out_result = mem[rd_ptr].result;
    assign out_flags  = mem[rd_ptr].flags;

    // Storage: cleared only by reset so out_* read zero straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_op_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (push),
        .clr      (stat_clr),
        .load_one (push),
        .q        (op_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (push & in_overflow),
        .clr      (stat_clr),
        .load_one (push & in_overflow),
        .q        (ovf_cnt)
    );

    // Sticky bring-up flags; a clear reloads them with this cycle's push only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            zero_err   <= 1'b0;
        end else if (stat_clr) begin
            ovf_sticky <= push & in_overflow;
            zero_err   <= push & zero_mis;
        end else if (push) begin
            ovf_sticky <= ovf_sticky | in_overflow;
            zero_err   <= zero_err | zero_mis;
        end
    end

endmodule
